vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source side of the raster interface consumed by all sprite/ROM renderers.
//  Generates DrawX/DrawY, the active-video flag blank (1 = visible pixel), and hs/vs.
//  Also produces frame/vblank event pulses, a frame counter and a sticky vblank flag
//  with an acknowledge handshake for game logic.
//  Sits between the pixel-clock source and every renderer/compositor plus the VGA pins.
// PARAMETERS
//  H_VISIBLE    640  visible pixels per line
//  H_FP         16   horizontal front porch (pixels)
//  H_SYNC       96   hsync pulse width (pixels)
//  H_BP         48   horizontal back porch (pixels)
//  V_VISIBLE    480  visible lines per frame
//  V_FP         10   vertical front porch (lines)
//  V_SYNC       2    vsync pulse width (lines)
//  V_BP         33   vertical back porch (lines)
//  FRAME_CNT_W  8    width of frame_count
//  Totals: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*; both must be <= 1024.
// PORTS
//  vga_clk      in   1            pixel clock; all logic on posedge
//  reset        in   1            asynchronous, active-high
//  DrawX        out  10           current pixel column, 0..H_TOTAL-1
//  DrawY        out  10           current line, 0..V_TOTAL-1
//  blank        out  1            1 when DrawX<H_VISIBLE && DrawY<V_VISIBLE
//  hs           out  1            hsync, active low
//  vs           out  1            vsync, active low
//  frame_start  out  1            1-cycle pulse at (0,0)
//  vblank_start out  1            1-cycle pulse at (0,V_VISIBLE)
//  frame_count  out  FRAME_CNT_W  completed visible frames, wraps
//  vblank_flag  out  1            sticky; set by vblank_start
//  vblank_ack   in   1            clears vblank_flag
// BEHAVIOUR
//  - Every output is a register. No combinational path from input to output.
//  - Reset (async) values:
//      DrawX = H_TOTAL-1, DrawY = V_TOTAL-1 (last pixel of frame)
//      blank = 0, hs = 1, vs = 1, frame_start = 0, vblank_start = 0
//      frame_count = 0, vblank_flag = 0
//  - The first posedge after reset deassertion presents (0,0) with blank = 1 and frame_start = 1.
//  - Counting, per edge:
//      DrawX increments. At H_TOTAL-1 it wraps to 0 and DrawY increments.
//      DrawY wraps to 0 after V_TOTAL-1 on an X wrap.
//  - Alignment: blank, hs, vs and the pulses are computed from the next counter values.
//    They always describe the DrawX/DrawY shown in the same cycle (zero skew).
//  - hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
//  - vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
//    vs therefore changes only when DrawX = 0.
//  - frame_count increments in the same edge that raises vblank_start, wrapping at 2^W.
//  - vblank_flag handshake:
//      set on the edge that raises vblank_start; vblank_ack = 1 sampled on an edge clears it
//      if set and ack coincide, set wins (flag stays 1)
//      ack while the flag is 0 has no effect
//  - Reset mid-frame: all outputs return to reset values immediately (async).
//    A pending vblank_flag is lost.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//      default timing localparams (640x480@60)
//      H_TOTAL/V_TOTAL computation functions
//      typedef coord_t = logic [9:0]
//  - Sub-module vga_axis_counter (params VISIBLE/FP/SYNC/BP):
//      wrap counter with an enable and a wrap-out
//      registered visible and sync_n flags
//    Instantiate it twice. The H instance's wrap-out drives the V instance's enable.
//  - The top level adds the event pulses, frame_count and vblank_flag.
// TESTING
//  1 Reset held, then released -> first edge: DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1.
//  2 One line -> blank falls at DrawX=640; hs low for exactly 96 cycles from DrawX=656; DrawX wraps 799->0, DrawY+1.
//  3 Full frame -> 420000 cycles; vblank_start at (0,480); vs low lines 490-491; frame_count 0->1; next frame_start at 420000.
//  4 vblank_ack pulsed in the same cycle as vblank_start -> flag stays 1; ack on the next cycle -> flag 0 on the following edge.
//  5 Reset asserted at (300,200) for 3 cycles -> outputs at reset values asynchronously; restart at (0,0); frame_count 0.
//  6 Params H=8/1/2/1, V=4/1/1/1 -> H_TOTAL=12, V_TOTAL=7; frame period 84 cycles; 256 frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults (640x480@60), coordinate type and timing-total helpers.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF   = 640;
    localparam int H_FP_DEF        = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_BP_DEF        = 48;
    localparam int V_VISIBLE_DEF   = 480;
    localparam int V_FP_DEF        = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_BP_DEF        = 33;
    localparam int FRAME_CNT_W_DEF = 8;

    typedef logic [9:0] coord_t;

    function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
        return axis_total(visible, fp, sync, bp);
    endfunction

    function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
        return axis_total(visible, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus from the timing generator to renderers and game logic.
interface vga_timing_if #(
    parameter int FRAME_CNT_W = 8
);
    import vga_timing_pkg::*;

    coord_t                   DrawX;
    coord_t                   DrawY;
    logic                     blank;
    logic                     hs;
    logic                     vs;
    logic                     frame_start;
    logic                     vblank_start;
    logic [FRAME_CNT_W-1:0]   frame_count;
    logic                     vblank_flag;
    logic                     vblank_ack;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, vblank_start,
        output frame_count, vblank_flag,
        input  vblank_ack
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, frame_start, vblank_start,
        input  frame_count, vblank_flag,
        output vblank_ack
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible and sync_n flags
// registered from the next count, so they line up with count_r.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FP      = 16,
    parameter int SYNC    = 96,
    parameter int BP      = 48
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count_r,
    output coord_t count_next_s,
    output logic   wrap_s,
    output logic   visible_r,
    output logic   sync_n_r
);

    localparam int     TOTAL    = axis_total(VISIBLE, FP, SYNC, BP);
    localparam coord_t LAST     = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END  = coord_t'(VISIBLE);
    localparam coord_t SYNC_BEG = coord_t'(VISIBLE + FP);
    localparam coord_t SYNC_END = coord_t'(VISIBLE + FP + SYNC);

    logic visible_next_s;
    logic sync_n_next_s;

    // Next position and the flags that will describe it.
    always_comb begin
        wrap_s       = 1'b0;
        count_next_s = count_r;
        if (en) begin
            if (count_r == LAST) begin
                wrap_s       = 1'b1;
                count_next_s = 10'd0;
            end else begin
                count_next_s = count_r + 10'd1;
            end
        end else begin
            count_next_s = count_r;
        end
        visible_next_s = (count_next_s < VIS_END);
        sync_n_next_s  = !((count_next_s >= SYNC_BEG) && (count_next_s < SYNC_END));
    end

    // Position and flag registers; reset parks on the last position of the axis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= LAST;
            visible_r <= 1'b0;
            sync_n_r  <= 1'b1;
        end else begin
            count_r   <= count_next_s;
            visible_r <= visible_next_s;
            sync_n_r  <= sync_n_next_s;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster source: pixel/line position, blank, syncs, frame/vblank events,
// frame counter and an acknowledged sticky vblank flag.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int FRAME_CNT_W = FRAME_CNT_W_DEF
) (
    input logic          vga_clk,
    input logic          reset,
    vga_timing_if.master vga
);

    localparam coord_t                 V_VIS_C = coord_t'(V_VISIBLE);
    localparam logic [FRAME_CNT_W-1:0] FC_ONE  = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_W-1:0] FC_ZERO = {FRAME_CNT_W{1'b0}};

    coord_t                 h_count_r, h_count_next_s, v_count_r, v_count_next_s;
    logic                   h_wrap_s, v_wrap_s;
    logic                   h_visible_r, v_visible_r, h_sync_n_r, v_sync_n_r;
    logic                   vblank_next_s, vblank_flag_next_s;
    logic                   frame_start_r, vblank_start_r, vblank_flag_r;
    logic [FRAME_CNT_W-1:0] frame_count_r;

    vga_axis_counter #(.VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(vga_clk), .rst(reset), .en(1'b1),
        .count_r(h_count_r), .count_next_s(h_count_next_s), .wrap_s(h_wrap_s),
        .visible_r(h_visible_r), .sync_n_r(h_sync_n_r)
    );

    vga_axis_counter #(.VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(vga_clk), .rst(reset), .en(h_wrap_s),
        .count_r(v_count_r), .count_next_s(v_count_next_s), .wrap_s(v_wrap_s),
        .visible_r(v_visible_r), .sync_n_r(v_sync_n_r)
    );

    // Vblank event for the upcoming pixel; a coinciding ack loses to the set.
    always_comb begin
        vblank_next_s      = (h_count_next_s == 10'd0) && (v_count_next_s == V_VIS_C);
        vblank_flag_next_s = vblank_flag_r;
        if (vblank_next_s) begin
            vblank_flag_next_s = 1'b1;
        end else if (vga.vblank_ack) begin
            vblank_flag_next_s = 1'b0;
        end else begin
            vblank_flag_next_s = vblank_flag_r;
        end
    end

    // Event pulses, frame counter and sticky flag; a vertical wrap means the next pixel is (0,0).
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
            frame_count_r  <= FC_ZERO;
            vblank_flag_r  <= 1'b0;
        end else begin
            frame_start_r  <= v_wrap_s;
            vblank_start_r <= vblank_next_s;
            vblank_flag_r  <= vblank_flag_next_s;
            if (vblank_next_s) begin
                frame_count_r <= frame_count_r + FC_ONE;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign vga.DrawX        = h_count_r;
    assign vga.DrawY        = v_count_r;
    assign vga.blank        = h_visible_r & v_visible_r;
    assign vga.hs           = h_sync_n_r;
    assign vga.vs           = v_sync_n_r;
    assign vga.frame_start  = frame_start_r;
    assign vga.vblank_start = vblank_start_r;
    assign vga.frame_count  = frame_count_r;
    assign vga.vblank_flag  = vblank_flag_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing over the first lines, and a tiny 12x7 raster
// for full-frame, vblank handshake, mid-frame reset and frame-counter wrap.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic vga_clk = 1'b0;
    logic rst_d;
    logic rst_s;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ed       = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_if #(.FRAME_CNT_W(8)) bus_d ();
    vga_timing_if #(.FRAME_CNT_W(8)) bus_s ();

    vga_timing_gen dut_d (.vga_clk(vga_clk), .reset(rst_d), .vga(bus_d));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FRAME_CNT_W(8)
    ) dut_s (.vga_clk(vga_clk), .reset(rst_s), .vga(bus_s));

    typedef struct {
        int         edge_n;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] flags; // {blank, hs, vs, frame_start, vblank_start}
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ed);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
        ed++;
    endtask

    function automatic logic [24:0] snap_d();
        return {bus_d.DrawX, bus_d.DrawY, bus_d.blank, bus_d.hs, bus_d.vs,
                bus_d.frame_start, bus_d.vblank_start};
    endfunction

    function automatic logic [24:0] snap_s();
        return {bus_s.DrawX, bus_s.DrawY, bus_s.blank, bus_s.hs, bus_s.vs,
                bus_s.frame_start, bus_s.vblank_start};
    endfunction

    // Expected 12x7 raster state at edge k after reset release (k >= 1).
    function automatic logic [32:0] model_s(input int k);
        int p;
        int x;
        int y;
        logic b;
        logic h;
        logic v;
        logic [7:0] fc;
        p  = (k - 1) % 84;
        x  = p % 12;
        y  = p / 12;
        b  = (x < 8) && (y < 4);
        h  = !((x >= 9) && (x < 11));
        v  = (y != 5);
        fc = 8'(((k - 1) / 84) + ((p >= 48) ? 1 : 0));
        return {10'(x), 10'(y), b, h, v, (p == 0), (p == 48), fc};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low;
        int hs_first;
        tbl[0]  = '{1,    10'd0,   10'd0, 5'b11110};
        tbl[1]  = '{2,    10'd1,   10'd0, 5'b11100};
        tbl[2]  = '{640,  10'd639, 10'd0, 5'b11100};
        tbl[3]  = '{641,  10'd640, 10'd0, 5'b01100};
        tbl[4]  = '{656,  10'd655, 10'd0, 5'b01100};
        tbl[5]  = '{657,  10'd656, 10'd0, 5'b00100};
        tbl[6]  = '{752,  10'd751, 10'd0, 5'b00100};
        tbl[7]  = '{753,  10'd752, 10'd0, 5'b01100};
        tbl[8]  = '{800,  10'd799, 10'd0, 5'b01100};
        tbl[9]  = '{801,  10'd0,   10'd1, 5'b11100};
        tbl[10] = '{1441, 10'd640, 10'd1, 5'b01100};

        rst_d = 1'b1;
        rst_s = 1'b1;
        bus_d.vblank_ack = 1'b0;
        bus_s.vblank_ack = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_d_outputs", snap_d(), {10'd799, 10'd524, 5'b01100});
        check("rst_d_fc_flag", {bus_d.frame_count, bus_d.vblank_flag}, 9'd0);

        // Default timing: table of positions across the first two lines.
        rst_d = 1'b0;
        ed = 0;
        for (int i = 0; i < 11; i++) begin
            while (ed < tbl[i].edge_n) tick();
            check($sformatf("line_vec%0d", i), snap_d(), {tbl[i].x, tbl[i].y, tbl[i].flags});
        end

        // Line 2: hsync width and start column.
        while (ed < 1600) tick();
        hs_low = 0;
        hs_first = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (bus_d.hs == 1'b0) begin
                if (hs_first < 0) hs_first = int'(bus_d.DrawX);
                hs_low++;
            end
        end
        check("hs_width", 64'(hs_low), 64'd96);
        check("hs_first_x", 64'(hs_first), 64'd656);
        check("line2_end", {bus_d.DrawX, bus_d.DrawY}, {10'd799, 10'd2});
        rst_d = 1'b1;

        // Small raster: reset values, then two full frames against the model.
        check("rst_s_outputs", snap_s(), {10'd11, 10'd6, 5'b01100});
        rst_s = 1'b0;
        ed = 0;
        for (int k = 1; k <= 168; k++) begin
            tick();
            check("frame_s", {snap_s(), bus_s.frame_count}, model_s(k));
        end

        // Flag handshake: clear, ack-while-clear, set/ack collision, ack next cycle, stickiness.
        check("flag_set_unacked", 64'(bus_s.vblank_flag), 64'd1);
        bus_s.vblank_ack = 1'b1;
        tick();
        bus_s.vblank_ack = 1'b0;
        check("ack_clear", 64'(bus_s.vblank_flag), 64'd0);
        bus_s.vblank_ack = 1'b1;
        tick();
        bus_s.vblank_ack = 1'b0;
        check("ack_when_clear", 64'(bus_s.vblank_flag), 64'd0);
        while (ed < 216) tick();
        bus_s.vblank_ack = 1'b1;
        tick();
        check("collide_vbs", 64'(bus_s.vblank_start), 64'd1);
        check("collide_set_wins", 64'(bus_s.vblank_flag), 64'd1);
        tick();
        bus_s.vblank_ack = 1'b0;
        check("ack_next_cycle", 64'(bus_s.vblank_flag), 64'd0);
        while (ed < 301) tick();
        check("flag_reset_by_vbs", 64'(bus_s.vblank_flag), 64'd1);
        repeat (10) tick();
        check("flag_sticky", 64'(bus_s.vblank_flag), 64'd1);
        check("pre_reset_pos", {snap_s(), bus_s.frame_count}, model_s(311));

        // Asynchronous reset mid-frame, held three edges, then restart.
        #2;
        rst_s = 1'b1;
        #1;
        check("async_rst_outputs", snap_s(), {10'd11, 10'd6, 5'b01100});
        check("async_rst_fc_flag", {bus_s.frame_count, bus_s.vblank_flag}, 9'd0);
        repeat (3) tick();
        check("rst_held", {snap_s(), bus_s.frame_count, bus_s.vblank_flag},
              {10'd11, 10'd6, 5'b01100, 8'd0, 1'b0});
        rst_s = 1'b0;
        ed = 0;
        tick();
        check("restart_origin", {snap_s(), bus_s.frame_count}, {10'd0, 10'd0, 5'b11110, 8'd0});

        // 256 vblanks wrap the 8-bit frame counter back to zero.
        while (ed < 49 + 84 * 254) tick();
        check("fc_255", 64'(bus_s.frame_count), 64'd255);
        while (ed < 49 + 84 * 255) tick();
        check("fc_wrap", {bus_s.vblank_start, bus_s.frame_count}, {1'b1, 8'd0});
        while (ed < 84 * 256 + 1) tick();
        check("frame_period", {snap_s(), bus_s.frame_count}, model_s(84 * 256 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
